// File: rtl/pe_ejection_buffer.sv
// Receive-side ejection buffer: queues router flits for the PE core and keeps
// a linear capture log of every accepted flit, readable through a debug port.
module pe_ejection_buffer #(
  parameter int FLIT_W    = 20,
  parameter int ID_W      = 4,
  parameter int NODE_ID   = 0,
  parameter int DEPTH     = 32,
  parameter int LOG_DEPTH = 32,
  localparam int AW  = $clog2(DEPTH),
  localparam int LAW = $clog2(LOG_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [FLIT_W-1:0] in_flit,
  output logic              in_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit,
  input  logic              out_ready,
  input  logic [LAW-1:0]    dbg_addr,
  output logic [FLIT_W-1:0] dbg_data,
  output logic [LAW:0]      log_count,
  output logic [15:0]       rx_total,
  output logic              err_self
);

  logic [FLIT_W-1:0] fifo_mem [DEPTH];
  logic [FLIT_W-1:0] log_mem  [LOG_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              full;
  logic              push;
  logic              pop;
  logic              log_full;

  // Handshake and flag decode; in_ready depends only on registered state and rst.
  always_comb begin
    full      = (count == (AW+1)'(DEPTH));
    in_ready  = !full && !rst;
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    log_full  = (log_count == (LAW+1)'(LOG_DEPTH));
    out_flit  = fifo_mem[rd_ptr];
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage is written only on an accepted flit, so idle-bus garbage never lands.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_flit;
  end

  // Capture-log storage fills linearly and then freezes.
  always_ff @(posedge clk) begin
    if (push && !log_full) log_mem[log_count[LAW-1:0]] <= in_flit;
  end

  // Log fill level, traffic counter, self-delivery flag and registered debug readout.
  always_ff @(posedge clk) begin
    if (rst) begin
      log_count <= '0;
      rx_total  <= '0;
      err_self  <= 1'b0;
      dbg_data  <= '0;
    end else begin
      if (push && !log_full) log_count <= log_count + 1'b1;
      if (push) rx_total <= rx_total + 16'd1;
      if (push && (in_flit[ID_W-1:0] == ID_W'(NODE_ID))) err_self <= 1'b1;
      dbg_data <= ({1'b0, dbg_addr} < log_count) ? log_mem[dbg_addr] : '0;
    end
  end

endmodule

// File: tb/tb_pe_ejection_buffer.sv
// Randomized scoreboard bench for pe_ejection_buffer (NODE_ID = 5).
module tb_pe_ejection_buffer;

  localparam int FW    = 20;
  localparam int DEPTH = 32;
  localparam int LDEP  = 32;
  localparam int NODE  = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [FW-1:0] in_flit;
  logic          in_ready;
  logic          out_valid;
  logic [FW-1:0] out_flit;
  logic          out_ready;
  logic [4:0]    dbg_addr;
  logic [FW-1:0] dbg_data;
  logic [5:0]    log_count;
  logic [15:0]   rx_total;
  logic          err_self;

  pe_ejection_buffer #(.FLIT_W(FW), .ID_W(4), .NODE_ID(NODE), .DEPTH(DEPTH), .LOG_DEPTH(LDEP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_flit(in_flit), .in_ready(in_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .log_count(log_count),
    .rx_total(rx_total), .err_self(err_self)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit checking = 0;

  // Reference model: plain queue of accepted flits plus occupancy and log bookkeeping.
  logic [FW-1:0] exp_q[$];
  logic [FW-1:0] m_log [LDEP];
  int            m_cnt  = 0;
  int            m_logc = 0;
  int            m_rx   = 0;
  bit            m_err  = 0;
  logic [FW-1:0] m_dbg  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each clock edge from the bench-driven inputs.
  initial begin
    bit push, pop;
    forever begin
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        m_cnt = 0; m_logc = 0; m_rx = 0; m_err = 0; m_dbg = '0;
      end else begin
        push  = in_valid && (m_cnt < DEPTH);
        pop   = (m_cnt != 0) && out_ready;
        m_dbg = (int'(dbg_addr) < m_logc) ? m_log[dbg_addr] : '0;
        if (push) begin
          exp_q.push_back(in_flit);
          if (m_logc < LDEP) begin
            m_log[m_logc] = in_flit;
            m_logc++;
          end
          m_rx = (m_rx + 1) % 65536;
          if (in_flit[3:0] == 4'(NODE)) m_err = 1;
        end
        m_cnt = m_cnt + int'(push) - int'(pop);
      end
    end
  end

  // Monitor: compares DUT outputs with the model and pops the scoreboard on each consume.
  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", 32'(in_ready), 32'((m_cnt < DEPTH) && !rst));
      chk("out_valid", 32'(out_valid), 32'(m_cnt != 0));
      chk("log_count", 32'(log_count), 32'(m_logc));
      chk("rx_total", 32'(rx_total), 32'(m_rx));
      chk("err_self", 32'(err_self), 32'(m_err));
      chk("dbg_data", 32'(dbg_data), 32'(m_dbg));
      if (out_valid) begin
        if (exp_q.size() == 0) chk("head_unexpected", 32'(out_flit), 32'hFFFF_FFFF);
        else chk("out_flit", 32'(out_flit), 32'(exp_q[0]));
        if (out_ready && !rst && exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dbg_addr = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [FW-1:0] f);
    in_valid = 1'b1; in_flit = f;
    tick();
    in_valid = 1'b0; in_flit = 'x;
  endtask

  initial begin
    logic [FW-1:0] f33;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_flit = '0; out_ready = 1'b0; dbg_addr = '0;
    repeat (3) tick();
    checking = 1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_log_count", 32'(log_count), 32'd0);
    chk("rst_rx_total", 32'(rx_total), 32'd0);
    chk("rst_dbg_data", 32'(dbg_data), 32'd0);

    // Two back-to-back pushes, PE stalled.
    rst = 1'b0;
    in_valid = 1'b1; in_flit = 20'hABCD1;
    tick();
    chk("t1_head", 32'(out_flit), 32'h000ABCD1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    in_flit = 20'h12342;
    tick();
    in_valid = 1'b0;
    chk("t1_log_count", 32'(log_count), 32'd2);
    chk("t1_rx_total", 32'(rx_total), 32'd2);

    // Fill to full, hold the 33rd offer, release one slot.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one({$urandom_range(0, 65535), 4'h2});
    chk("t2_full_ready", 32'(in_ready), 32'd0);
    f33 = 20'h3333A;
    in_valid = 1'b1; in_flit = f33;
    tick(); tick();
    chk("t2_held_rx", 32'(rx_total), 32'd32);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_ready_after_pop", 32'(in_ready), 32'd1);
    guard = 0;
    while (rx_total != 16'd33 && guard < 10) begin tick(); guard++; end
    in_valid = 1'b0;
    chk("t2_accept_33", 32'(rx_total), 32'd33);
    out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    out_ready = 1'b0;
    chk("t2_drained", 32'(out_valid), 32'd0);

    // Streaming with pointer wrap and log saturation.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; in_flit = {16'(i), 4'h1};
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t3_log_sat", 32'(log_count), 32'd32);
    chk("t3_empty", 32'(out_valid), 32'd0);
    dbg_addr = 5'd31;
    tick(); tick();
    chk("t3_dbg31", 32'(dbg_data), 32'h000001F1);
    dbg_addr = 5'd0;
    tick();
    chk("t3_dbg0", 32'(dbg_data), 32'h00000001);

    // Self-delivery flag.
    do_reset();
    out_ready = 1'b0;
    push_one(20'h00011);
    chk("t4_no_err", 32'(err_self), 32'd0);
    push_one(20'h00015);
    chk("t4_err_set", 32'(err_self), 32'd1);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("t4_err_sticky", 32'(err_self), 32'd1);
    chk("t4_delivered", 32'(out_valid), 32'd0);

    // Unused log addresses read zero.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(20'hC0DE2 + 20'(i << 4));
    dbg_addr = 5'd10;
    tick(); tick();
    chk("dbg_unused", 32'(dbg_data), 32'd0);

    // Reset mid-stream with a flit offered.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) push_one({16'(i + 100), 4'h3});
    in_valid = 1'b1; in_flit = 20'hDEAD3;
    rst = 1'b1;
    tick();
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    chk("t5_log", 32'(log_count), 32'd0);
    rst = 1'b0;
    in_flit = 20'h77773;
    tick();
    in_valid = 1'b0;
    chk("t5_new_head", 32'(out_flit), 32'h00077773);
    out_ready = 1'b1;
    tick(); tick();

    // Random traffic.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_flit   = in_valid ? FW'($urandom) : 'x;
      out_ready = ($urandom_range(0, 99) < 50);
      dbg_addr  = 5'($urandom);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("rand_drained", 32'(out_valid), 32'd0);

    // Long stream: rx_total wraps.
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      in_flit = {16'($urandom), 4'h4};
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk("t6_rx_wrap", 32'(rx_total), 32'd1);
    chk("t6_empty", 32'(out_valid), 32'd0);

    checking = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
